sram_fifo_axis_reader: RTL and testbench

Read-side egress stage of the SRAM packet FIFO. Sits directly downstream of `FifoMem`:
- Selects a non-empty queue round-robin at packet granularity.
- Issues single-word read requests to `FifoMem` under a credit limit.
- Absorbs variable memory latency in an output FIFO.
- Re-emits the stored words as an AXI4-Stream master toward the output queues.

---
 rtl/sram_fifo_axis_reader.sv | 180 ++++++++++++++++++
 tb/tb_sram_fifo_axis_reader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_axis_reader.sv
// Read-side egress of the SRAM packet FIFO: round-robin packet fetch from FifoMem
// under a credit limit, buffered in a FWFT output FIFO and replayed as AXI4-Stream.
module sram_fifo_axis_reader #(
    parameter int TDATA_WIDTH         = 32,
    parameter int TUSER_WIDTH         = 128,
    parameter int NUM_QUEUES          = 4,
    parameter int QUEUE_ID_WIDTH      = 2,
    parameter int OUT_FIFO_DEPTH_BITS = 4
) (
    input  logic                        axi_aclk,
    input  logic                        axi_resetn,
    output logic [QUEUE_ID_WIDTH-1:0]   read_queue_id,
    output logic                        read_data_ready,
    input  logic                        read_burst_state,
    input  logic [NUM_QUEUES-1:0]       read_empty,
    input  logic [8*TDATA_WIDTH+8:0]    read_data,
    input  logic                        read_data_valid,
    input  logic [QUEUE_ID_WIDTH-1:0]   read_data_queue_id,
    output logic [8*TDATA_WIDTH-1:0]    m_axis_tdata,
    output logic [TDATA_WIDTH-1:0]      m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [31:0]                 pkt_count,
    output logic [15:0]                 qid_err_count
);

    localparam int DW    = 8 * TDATA_WIDTH;
    localparam int WW    = DW + 9;
    localparam int EW    = WW + QUEUE_ID_WIDTH;
    localparam int DEPTH = 1 << OUT_FIFO_DEPTH_BITS;
    localparam int CW    = OUT_FIFO_DEPTH_BITS + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                         state_q;
    logic [QUEUE_ID_WIDTH-1:0]      cur_q_q, rr_ptr_q;
    logic                           last_seen_q;
    logic [CW-1:0]                  outstanding_q, outstanding_d;
    logic [CW-1:0]                  fifo_count_q, fifo_count_d;
    logic [OUT_FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]                  mem_q [DEPTH];
    logic [31:0]                    pkt_count_q;
    logic [15:0]                    qid_err_q;

    logic                           found;
    logic [QUEUE_ID_WIDTH-1:0]      pick, cand, rr_next;
    logic [CW:0]                    in_use;
    logic                           credit_ok, accept, push, pop, word_last;
    logic [EW-1:0]                  head;
    logic [7:0]                     head_cnt;
    logic [QUEUE_ID_WIDTH-1:0]      head_q;

    assign word_last       = read_data[DW+8];
    assign in_use          = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
    assign credit_ok       = in_use < (CW+1)'(DEPTH);
    assign read_queue_id   = cur_q_q;
    assign read_data_ready = (state_q == FETCH) && credit_ok && !read_empty[cur_q_q];
    assign accept          = read_data_ready && !read_burst_state && !read_empty[read_queue_id];
    assign rr_next         = (int'(cur_q_q) == NUM_QUEUES - 1) ? '0 : cur_q_q + 1'b1;

    assign head          = mem_q[rd_ptr_q];
    assign head_cnt      = head[DW+7:DW];
    assign head_q        = head[EW-1:WW];
    assign m_axis_tvalid = (fifo_count_q != '0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign push          = read_data_valid && ((fifo_count_q != CW'(DEPTH)) || pop);
    assign pkt_count     = pkt_count_q;
    assign qid_err_count = qid_err_q;

    // First non-empty queue at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            cand = QUEUE_ID_WIDTH'((int'(rr_ptr_q) + i) % NUM_QUEUES);
            if (!found && !read_empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        m_axis_tuser = '0;
        m_axis_tlast = 1'b0;
        if (m_axis_tvalid) begin
            m_axis_tdata = head[DW-1:0];
            m_axis_tlast = head[DW+8];
            for (int b = 0; b < TDATA_WIDTH; b++) begin
                m_axis_tkeep[b] = (int'(head_cnt) > b);
            end
            if (head_cnt == 8'd0 || int'(head_cnt) > TDATA_WIDTH) begin
                m_axis_tkeep = '1;
            end
            for (int b = 0; b < 8; b++) begin
                m_axis_tuser[24+b] = (2 * int'(head_q) == b);
            end
        end
    end

    always_comb begin
        fifo_count_d = fifo_count_q;
        if (push && !pop) fifo_count_d = fifo_count_q + 1'b1;
        else if (!push && pop) fifo_count_d = fifo_count_q - 1'b1;

        outstanding_d = outstanding_q;
        if (accept && !read_data_valid) outstanding_d = outstanding_q + 1'b1;
        else if (!accept && read_data_valid && outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
    end

    // Storage carries the queue that was current when the word arrived, so tuser
    // stays correct even after the scheduler has moved on to another queue.
    always_ff @(posedge axi_aclk) begin
        if (push) mem_q[wr_ptr_q] <= {cur_q_q, read_data};
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pkt_count_q   <= '0;
            qid_err_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pop && head[DW+8]) pkt_count_q <= pkt_count_q + 1'b1;
            if (read_data_valid && read_data_queue_id != cur_q_q && qid_err_q != 16'hFFFF) begin
                qid_err_q <= qid_err_q + 1'b1;
            end
        end
    end

    // A queue is only released once the last returned word closed a packet;
    // over-fetched words belonging to the next packet send us back to FETCH.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= IDLE;
            cur_q_q     <= '0;
            rr_ptr_q    <= '0;
            last_seen_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        cur_q_q <= pick;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (read_data_valid) begin
                        last_seen_q <= word_last;
                        if (word_last) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (read_data_valid) last_seen_q <= word_last;
                    if (outstanding_q == '0) begin
                        if (last_seen_q) begin
                            rr_ptr_q <= rr_next;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_fifo_axis_reader.sv
// Scoreboard bench: a FifoMem model answers read requests, expected beats are queued
// per memory queue at load time and a monitor checks every accepted m_axis beat.
module tb_sram_fifo_axis_reader;

    localparam int TW = 32;
    localparam int DW = 256;
    localparam int WW = 265;
    localparam int NQ = 4;

    logic            axi_aclk;
    logic            axi_resetn;
    logic [1:0]      read_queue_id;
    logic            read_data_ready;
    logic            read_burst_state;
    logic [NQ-1:0]   read_empty;
    logic [WW-1:0]   read_data;
    logic            read_data_valid;
    logic [1:0]      read_data_queue_id;
    logic [DW-1:0]   m_axis_tdata;
    logic [TW-1:0]   m_axis_tkeep;
    logic [127:0]    m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [31:0]     pkt_count;
    logic [15:0]     qid_err_count;

    typedef struct { logic [DW-1:0] data; logic [TW-1:0] keep; logic last; } beat_t;
    typedef struct { int due; logic [WW-1:0] word; logic [1:0] tag; } ret_t;
    typedef struct { int q; logic [TW-1:0] keep; logic last; logic [7:0] dest; } obs_t;

    beat_t         expQ [NQ][$];
    logic [WW-1:0] memQ [NQ][$];
    ret_t          pend [$];
    obs_t          obsLog [$];

    int checks = 0, failures = 0;
    int cyc = 0, lastDue = 0, latMin = 1, latMax = 1, readyMode = 1;
    int accepted = 0, popped = 0, maxInFlight = 0, pktTotal = 0, pktQ = 0;
    bit randBusy = 0, corruptNext = 0, inPkt = 0;
    int t2Order [4] = '{0, 1, 0, 1};
    int t4Order [6] = '{3, 3, 3, 3, 3, 0};

    sram_fifo_axis_reader dut (
        .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
        .read_queue_id(read_queue_id), .read_data_ready(read_data_ready),
        .read_burst_state(read_burst_state), .read_empty(read_empty),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .read_data_queue_id(read_data_queue_id),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .pkt_count(pkt_count), .qid_err_count(qid_err_count)
    );

    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    function automatic logic [TW-1:0] keepFromCount(int cnt);
        if (cnt == 0 || cnt > TW) return '1;
        return ~({TW{1'b1}} << cnt);
    endfunction

    function automatic bit allDone();
        for (int i = 0; i < NQ; i++) begin
            if (memQ[i].size() != 0 || expQ[i].size() != 0) return 1'b0;
        end
        return pend.size() == 0;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pushWord(input int q, input int cnt, input bit last);
        logic [DW-1:0] d;
        beat_t b;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        memQ[q].push_back({last, 8'(cnt), d});
        b.data = d;
        b.keep = keepFromCount(cnt);
        b.last = last;
        expQ[q].push_back(b);
        if (last) pktTotal++;
    endtask

    task automatic applyStimulus(input int q, input int len);
        for (int i = 0; i < len; i++) pushWord(q, int'($urandom_range(0, 40)), i == len - 1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (n < budget && !allDone()) begin
            @(posedge axi_aclk);
            n++;
        end
        checkOutput("drain_within_budget", 256'(allDone()), 256'(1));
        repeat (20) @(posedge axi_aclk);
        @(negedge axi_aclk);
    endtask

    // FifoMem model: in-order returns after a per-request latency, slot busy after each accept.
    initial begin
        bit   acc;
        int   q, lat;
        ret_t r;
        read_burst_state   = 1'b0;
        read_empty         = '1;
        read_data          = '0;
        read_data_valid    = 1'b0;
        read_data_queue_id = '0;
        m_axis_tready      = 1'b1;
        forever begin
            @(negedge axi_aclk);
            acc = axi_resetn && read_data_ready && !read_burst_state && !read_empty[read_queue_id];
            q   = int'(read_queue_id);
            @(posedge axi_aclk);
            #1;
            cyc++;
            if (acc && memQ[q].size() > 0) begin
                lat   = int'($urandom_range(latMin, latMax));
                r.due = cyc - 1 + lat;
                if (r.due <= lastDue) r.due = lastDue + 1;
                lastDue = r.due;
                r.word  = memQ[q].pop_front();
                r.tag   = 2'(q);
                pend.push_back(r);
                accepted++;
            end
            read_burst_state = acc || (randBusy && $urandom_range(0, 3) == 0);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                r = pend.pop_front();
                read_data_valid    = 1'b1;
                read_data          = r.word;
                read_data_queue_id = corruptNext ? (r.tag ^ 2'd1) : r.tag;
                corruptNext        = 1'b0;
            end else begin
                read_data_valid = 1'b0;
                read_data       = '0;
            end
            for (int i = 0; i < NQ; i++) read_empty[i] = (memQ[i].size() == 0);
            m_axis_tready = (readyMode == 2) ? 1'($urandom_range(0, 1)) : (readyMode == 1);
        end
    end

    // Monitor: every accepted beat is matched against the queue its tuser names.
    initial begin
        int   q;
        obs_t o;
        beat_t b;
        forever begin
            @(negedge axi_aclk);
            if (!axi_resetn) begin
                inPkt = 1'b0;
            end else begin
                if (accepted - popped > maxInFlight) maxInFlight = accepted - popped;
                if (m_axis_tvalid && m_axis_tready) begin
                    popped++;
                    q = -1;
                    for (int i = 0; i < NQ; i++) begin
                        if (m_axis_tuser == (128'(8'(1 << (2 * i))) << 24)) q = i;
                    end
                    checks++;
                    if (q < 0) begin
                        failures++;
                        $display("[TB] FAIL tuser_pattern actual=%0h expected=one-hot dest", m_axis_tuser);
                    end else if (expQ[q].size() == 0) begin
                        failures++;
                        $display("[TB] FAIL unexpected_beat actual=queue %0d expected=no beat", q);
                    end else begin
                        b = expQ[q].pop_front();
                        checkOutput("beat_data", m_axis_tdata, b.data);
                        checkOutput("beat_keep", 256'(m_axis_tkeep), 256'(b.keep));
                        checkOutput("beat_last", 256'(m_axis_tlast), 256'(b.last));
                        if (inPkt) checkOutput("no_interleave", 256'(q), 256'(pktQ));
                        inPkt = !m_axis_tlast;
                        pktQ  = q;
                    end
                    o.q    = q;
                    o.keep = m_axis_tkeep;
                    o.last = m_axis_tlast;
                    o.dest = m_axis_tuser[31:24];
                    obsLog.push_back(o);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        axi_resetn = 1'b0;
        repeat (3) @(negedge axi_aclk);
        checkOutput("rst_ready", 256'(read_data_ready), 256'(0));
        checkOutput("rst_qid", 256'(read_queue_id), 256'(0));
        checkOutput("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        checkOutput("rst_tkeep", 256'(m_axis_tkeep), 256'(0));
        checkOutput("rst_pkt_count", 256'(pkt_count), 256'(0));
        axi_resetn = 1'b1;

        $display("[TB] single 3-word packet on queue 2");
        latMin = 3; latMax = 3;
        obsLog.delete();
        pushWord(2, 32, 1'b0);
        pushWord(2, 32, 1'b0);
        pushWord(2, 5, 1'b1);
        waitIdle(500);
        checkOutput("t1_pkt_count", 256'(pkt_count), 256'(1));
        checkOutput("t1_beats", 256'(obsLog.size()), 256'(3));
        if (obsLog.size() == 3) begin
            checkOutput("t1_keep3", 256'(obsLog[2].keep), 256'(32'h0000001F));
            checkOutput("t1_last3", 256'(obsLog[2].last), 256'(1));
            checkOutput("t1_dest", 256'(obsLog[2].dest), 256'(8'h10));
        end

        $display("[TB] round robin between queues 0 and 1");
        latMin = 1; latMax = 1;
        obsLog.delete();
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        waitIdle(500);
        checkOutput("t2_beats", 256'(obsLog.size()), 256'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < obsLog.size()) checkOutput("t2_order", 256'(obsLog[i].q), 256'(t2Order[i]));
        end
        checkOutput("t2_pkt_count", 256'(pkt_count), 256'(pktTotal));

        $display("[TB] backpressure with a 30-word packet");
        latMin = 2; latMax = 2;
        readyMode = 0;
        maxInFlight = 0;
        applyStimulus(1, 30);
        repeat (40) @(posedge axi_aclk);
        readyMode = 1;
        waitIdle(2000);
        checkOutput("t3_credit_peak", 256'(maxInFlight), 256'(16));
        checkOutput("t3_pkt_count", 256'(pkt_count), 256'(pktTotal));

        $display("[TB] over-fetch into the next packet of queue 3");
        latMin = 6; latMax = 6;
        obsLog.delete();
        applyStimulus(3, 1);
        applyStimulus(3, 4);
        applyStimulus(0, 1);
        waitIdle(1000);
        checkOutput("t4_beats", 256'(obsLog.size()), 256'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < obsLog.size()) checkOutput("t4_order", 256'(obsLog[i].q), 256'(t4Order[i]));
        end

        $display("[TB] mismatched return tag while serving queue 0");
        latMin = 2; latMax = 2;
        corruptNext = 1'b1;
        applyStimulus(0, 2);
        waitIdle(500);
        checkOutput("t5_qid_err", 256'(qid_err_count), 256'(1));
        checkOutput("t5_pkt_count", 256'(pkt_count), 256'(pktTotal));

        $display("[TB] randomized traffic");
        latMin = 1; latMax = 8;
        randBusy = 1'b1;
        readyMode = 2;
        maxInFlight = 0;
        for (int i = 0; i < 30; i++) applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
        repeat (200) @(posedge axi_aclk);
        for (int i = 0; i < 30; i++) applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
        waitIdle(20000);
        checkOutput("t6_pkt_count", 256'(pkt_count), 256'(pktTotal));
        checkOutput("t6_qid_err", 256'(qid_err_count), 256'(1));
        checkOutput("t6_credit_bound", 256'(maxInFlight <= 16), 256'(1));
        randBusy = 1'b0;
        readyMode = 1;

        $display("[TB] reset with requests outstanding");
        latMin = 8; latMax = 8;
        applyStimulus(2, 10);
        n = 0;
        while (n < 200 && pend.size() < 3) begin
            @(posedge axi_aclk);
            n++;
        end
        checkOutput("t7_inflight_reached", 256'(pend.size() >= 3), 256'(1));
        @(negedge axi_aclk);
        axi_resetn = 1'b0;
        #1;
        checkOutput("t7_ready", 256'(read_data_ready), 256'(0));
        checkOutput("t7_qid", 256'(read_queue_id), 256'(0));
        checkOutput("t7_tvalid", 256'(m_axis_tvalid), 256'(0));
        checkOutput("t7_tdata", m_axis_tdata, 256'(0));
        checkOutput("t7_tuser", 256'(m_axis_tuser), 256'(0));
        checkOutput("t7_tlast", 256'(m_axis_tlast), 256'(0));
        checkOutput("t7_pkt_count", 256'(pkt_count), 256'(0));
        checkOutput("t7_qid_err", 256'(qid_err_count), 256'(0));
        for (int i = 0; i < NQ; i++) begin
            memQ[i].delete();
            expQ[i].delete();
        end
        pend.delete();
        pktTotal = 0;
        accepted = 0;
        popped = 0;
        repeat (3) @(negedge axi_aclk);
        axi_resetn = 1'b1;
        latMin = 2; latMax = 2;
        applyStimulus(1, 2);
        waitIdle(500);
        checkOutput("t7_recover_pkt_count", 256'(pkt_count), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
